// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared bus widths, bus layouts and exception codes for the memory stage
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 128;
  localparam int MS_TO_WS_BUS_WD = 123;
  localparam int MS_FWD_BUS_WD = 43;
  localparam int C0_MFC0 = 8;
  localparam logic [4:0] EX_INT = 5'h00;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;
  localparam logic [4:0] EX_SYS = 5'h08;
  localparam logic [4:0] EX_BP = 5'h09;
  localparam logic [4:0] EX_RI = 5'h0a;
  localparam logic [4:0] EX_OV = 5'h0c;
  typedef struct packed {
    logic lw;
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lwl;
    logic lwr;
  } ld_inst_t;
  typedef struct packed {
    logic [31:0] badvaddr;
    logic [10:0] c0_bus;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    ld_inst_t    ld_inst;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] pc;
  } es_to_ms_t;
  typedef struct packed {
    logic [31:0] badvaddr;
    logic [10:0] c0_bus;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [3:0]  rf_wen;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;
  typedef struct packed {
    logic        mfc0_valid;
    logic        block_valid;
    logic [3:0]  rf_wen;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_fwd_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: extracts and aligns load data and produces per-byte register write strobes
module load_align
  import mem_stage_pkg::*;
(
  input  ld_inst_t    ld_inst,
  input  logic [1:0]  offset,
  input  logic [31:0] ld_word,
  output logic [31:0] result,
  output logic [3:0]  wen
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = ld_word[{offset, 3'b000} +: 8];
    h = offset[1] ? ld_word[31:16] : ld_word[15:0];
    result = ld_inst.lw  ? ld_word :
             ld_inst.lb  ? {{24{b[7]}}, b} :
             ld_inst.lbu ? {24'h0, b} :
             ld_inst.lh  ? {{16{h[15]}}, h} :
             ld_inst.lhu ? {16'h0, h} :
             ld_inst.lwl ? ld_word << {~offset, 3'b000} :
             ld_inst.lwr ? ld_word >> {offset, 3'b000} : ld_word;
    wen = ld_inst.lwl ? ~(4'b0111 >> offset) :
          ld_inst.lwr ? 4'b1111 >> offset : 4'b1111;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with load alignment, read-data hold and forwarding
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
  output logic                       ms_ex,
  input  logic                       flush
);
  logic ms_valid_q, ms_valid_d, buf_valid_q, buf_valid_d;
  logic [31:0] rdata_buf_q, rdata_buf_d, ld_word, ld_result, final_result;
  logic [3:0] ld_wen, rf_wen;
  es_to_ms_t bus_q, bus_d;
  ms_to_ws_t ws;
  ms_fwd_t fwd;
  assign ms_allowin = !ms_valid_q || ws_allowin;
  assign ld_word = buf_valid_q ? rdata_buf_q : data_sram_rdata;
  load_align u_align (
    .ld_inst (bus_q.ld_inst),
    .offset  (bus_q.res[1:0]),
    .ld_word (ld_word),
    .result  (ld_result),
    .wen     (ld_wen)
  );
  always_comb begin
    ms_valid_d = flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid_q;
    bus_d = (es_to_ms_valid && ms_allowin) ? es_to_ms_t'(es_to_ms_bus) : bus_q;
    buf_valid_d = (ms_allowin || flush) ? 1'b0 :
                  (ms_valid_q && !ws_allowin) ? 1'b1 : buf_valid_q;
    rdata_buf_d = (ms_valid_q && !buf_valid_q && !ws_allowin) ? data_sram_rdata : rdata_buf_q;
    final_result = bus_q.res_from_mem ? ld_result : bus_q.res;
    rf_wen = bus_q.ex ? 4'b0000 : bus_q.res_from_mem ? ld_wen : {4{bus_q.gr_we}};
    ws = '{badvaddr: bus_q.badvaddr, c0_bus: bus_q.c0_bus, bd: bus_q.bd, ex: bus_q.ex,
           excode: bus_q.excode, rf_wen: rf_wen, dest: bus_q.dest,
           final_result: final_result, pc: bus_q.pc};
    fwd = '{mfc0_valid: bus_q.c0_bus[C0_MFC0] && ms_valid_q,
            block_valid: ms_valid_q && bus_q.gr_we && !flush,
            rf_wen: rf_wen, dest: bus_q.dest, final_result: final_result};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      ms_valid_q <= ms_valid_d;
      buf_valid_q <= buf_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    bus_q <= bus_d;
    rdata_buf_q <= rdata_buf_d;
  end
  assign ms_to_ws_valid = ms_valid_q && !flush;
  assign ms_to_ws_bus = ws;
  assign ms_fwd_bus = fwd;
  assign ms_ex = ms_valid_q && bus_q.ex;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, corner sequences and randomized model comparison for mem_stage
module tb_mem_stage;
  logic clk = 1'b0, reset = 1'b1, ws_allowin = 1'b1, es_to_ms_valid = 1'b0, flush = 1'b0;
  logic [127:0] es_to_ms_bus = '0;
  logic [31:0] data_sram_rdata = '0;
  logic ms_allowin, ms_to_ws_valid, ms_ex;
  logic [122:0] ms_to_ws_bus;
  logic [42:0] ms_fwd_bus;
  int checks = 0, errors = 0;
  localparam logic [6:0] LW = 7'b1000000, LB = 7'b0100000, LBU = 7'b0010000, LH = 7'b0001000,
                         LHU = 7'b0000100, LWL = 7'b0000010, LWR = 7'b0000001;
  always #5 clk = ~clk;
  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_fwd_bus      (ms_fwd_bus),
    .ms_ex           (ms_ex),
    .flush           (flush)
  );
  logic [31:0] o_badv, o_res, o_pc, f_res;
  logic [10:0] o_c0;
  logic [4:0] o_code, o_dest;
  logic [3:0] o_wen, f_wen;
  logic o_bd, o_ex, f_mfc0, f_blk;
  assign o_badv = ms_to_ws_bus[122:91];
  assign o_c0 = ms_to_ws_bus[90:80];
  assign o_bd = ms_to_ws_bus[79];
  assign o_ex = ms_to_ws_bus[78];
  assign o_code = ms_to_ws_bus[77:73];
  assign o_wen = ms_to_ws_bus[72:69];
  assign o_dest = ms_to_ws_bus[68:64];
  assign o_res = ms_to_ws_bus[63:32];
  assign o_pc = ms_to_ws_bus[31:0];
  assign f_mfc0 = ms_fwd_bus[42];
  assign f_blk = ms_fwd_bus[41];
  assign f_wen = ms_fwd_bus[40:37];
  assign f_res = ms_fwd_bus[31:0];

  function automatic logic [127:0] mk_bus(input logic [31:0] badv, input logic [10:0] c0,
      input logic bd, input logic ex, input logic [4:0] code, input logic [6:0] ld,
      input logic rfm, input logic gwe, input logic [4:0] dest, input logic [31:0] res,
      input logic [31:0] pc);
    return {badv, c0, bd, ex, code, ld, rfm, gwe, dest, res, pc};
  endfunction

  function automatic void ref_load(input logic [6:0] ld, input logic [1:0] k, input logic [31:0] w,
      output logic [31:0] r, output logic [3:0] m);
    logic [7:0] b [4];
    logic [15:0] h;
    int ki;
    ki = int'(k);
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    h = {b[(ki/2)*2+1], b[(ki/2)*2]};
    r = w;
    m = 4'hF;
    if (ld[5]) r = {{24{b[ki][7]}}, b[ki]};
    else if (ld[4]) r = {24'h0, b[ki]};
    else if (ld[3]) r = {{16{h[15]}}, h};
    else if (ld[2]) r = {16'h0, h};
    else if (ld[1]) begin
      r = '0; m = '0;
      for (int i = 0; i < 4; i++) if (i + 3 - ki <= 3) begin r[8*(i+3-ki) +: 8] = b[i]; m[i+3-ki] = 1'b1; end
    end else if (ld[0]) begin
      r = '0; m = '0;
      for (int i = 0; i < 4; i++) if (i - ki >= 0) begin r[8*(i-ki) +: 8] = b[i]; m[i-ki] = 1'b1; end
    end
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [6:0]  ld;
    logic        rfm;
    logic        gwe;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [31:0] exp_res;
    logic [3:0]  exp_wen;
  } vec_t;
  vec_t vt [14];

  logic m_valid, m_first;
  logic [127:0] m_bus;
  logic [31:0] m_word, e_res, word;
  logic [3:0] e_wen;
  logic [6:0] r_ld;
  logic r_rfm, r_gwe, r_ex, e_allow;

  initial begin
    vt[0]  = '{LB,  1'b1, 1'b1, 32'h1003, 32'h80ABCD12, 32'hFFFFFF80, 4'hF};
    vt[1]  = '{LBU, 1'b1, 1'b1, 32'h1003, 32'h80ABCD12, 32'h00000080, 4'hF};
    vt[2]  = '{LWL, 1'b1, 1'b1, 32'h1001, 32'h11223344, 32'h33440000, 4'hC};
    vt[3]  = '{LWR, 1'b1, 1'b1, 32'h1002, 32'h11223344, 32'h00001122, 4'h3};
    vt[4]  = '{LW,  1'b1, 1'b1, 32'h1000, 32'h12345678, 32'h12345678, 4'hF};
    vt[5]  = '{LH,  1'b1, 1'b1, 32'h2002, 32'h80017FFF, 32'hFFFF8001, 4'hF};
    vt[6]  = '{LHU, 1'b1, 1'b1, 32'h2000, 32'h80017FFF, 32'h00007FFF, 4'hF};
    vt[7]  = '{LWL, 1'b1, 1'b1, 32'h0000, 32'h11223344, 32'h44000000, 4'h8};
    vt[8]  = '{LWL, 1'b1, 1'b1, 32'h0003, 32'h11223344, 32'h11223344, 4'hF};
    vt[9]  = '{LWR, 1'b1, 1'b1, 32'h0000, 32'h11223344, 32'h11223344, 4'hF};
    vt[10] = '{LWR, 1'b1, 1'b1, 32'h0003, 32'h11223344, 32'h00000011, 4'h1};
    vt[11] = '{LB,  1'b1, 1'b1, 32'h1001, 32'h80ABCD12, 32'hFFFFFFCD, 4'hF};
    vt[12] = '{7'h0, 1'b0, 1'b1, 32'hCAFEBABE, 32'h0, 32'hCAFEBABE, 4'hF};
    vt[13] = '{7'h0, 1'b0, 1'b0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 4'h0};
    repeat (2) tick;
    #2;
    chk("reset_to_ws_valid", 32'(ms_to_ws_valid), 0);
    chk("reset_allowin", 32'(ms_allowin), 1);
    chk("reset_ms_ex", 32'(ms_ex), 0);
    chk("reset_block_valid", 32'(f_blk), 0);
    chk("reset_mfc0_valid", 32'(f_mfc0), 0);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick;
      es_to_ms_valid = 1'b1;
      ws_allowin = 1'b1;
      es_to_ms_bus = mk_bus(0, 0, 0, 0, 0, vt[i].ld, vt[i].rfm, vt[i].gwe, 5'd3, vt[i].res, 32'h400 + 32'(i*4));
      tick;
      es_to_ms_valid = 1'b0;
      data_sram_rdata = vt[i].rdata;
      #2;
      chk($sformatf("vec%0d_valid", i), 32'(ms_to_ws_valid), 1);
      chk($sformatf("vec%0d_result", i), o_res, vt[i].exp_res);
      chk($sformatf("vec%0d_wen", i), 32'(o_wen), 32'(vt[i].exp_wen));
      chk($sformatf("vec%0d_fwd_result", i), f_res, vt[i].exp_res);
    end
    // stall: data from first cycle must persist
    tick;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(0, 0, 0, 0, 0, LW, 1, 1, 5'd4, 32'h100, 32'h800);
    tick;
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_rdata = 32'h12345678;
    #2;
    chk("stall0_result", o_res, 32'h12345678);
    chk("stall0_allowin", 32'(ms_allowin), 0);
    for (int c = 1; c < 3; c++) begin
      tick;
      data_sram_rdata = 32'hDEADBEEF;
      #2;
      chk($sformatf("stall%0d_result", c), o_res, 32'h12345678);
      chk($sformatf("stall%0d_valid", c), 32'(ms_to_ws_valid), 1);
      chk($sformatf("stall%0d_allowin", c), 32'(ms_allowin), 0);
    end
    tick;
    ws_allowin = 1'b1;
    #2;
    chk("release_result", o_res, 32'h12345678);
    chk("release_allowin", 32'(ms_allowin), 1);
    tick;
    #2;
    chk("release_empty", 32'(ms_to_ws_valid), 0);
    // exception
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(32'h1001, 0, 0, 1, 5'h04, LW, 1, 1, 5'd5, 32'h1001, 32'h900);
    tick;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(32'h2222, 11'h100, 1, 1, 5'h0a, 7'h0, 0, 0, 5'd6, 32'h5, 32'h904);
    #2;
    chk("ex_ms_ex", 32'(ms_ex), 1);
    chk("ex_wen", 32'(o_wen), 0);
    chk("ex_fwd_wen", 32'(f_wen), 0);
    chk("ex_excode", 32'(o_code), 32'h04);
    chk("ex_badvaddr", o_badv, 32'h1001);
    chk("ex_block_valid", 32'(f_blk), 1);
    tick;
    es_to_ms_valid = 1'b0;
    #2;
    chk("ex2_ms_ex", 32'(ms_ex), 1);
    chk("ex2_block_valid", 32'(f_blk), 0);
    chk("ex2_mfc0_valid", 32'(f_mfc0), 1);
    chk("ex2_bd", 32'(o_bd), 1);
    chk("ex2_c0", 32'(o_c0), 32'h100);
    // flush with a held load and a new instruction arriving
    tick;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(0, 0, 0, 0, 0, LW, 1, 1, 5'd7, 32'h0, 32'hA00);
    tick;
    ws_allowin = 1'b0;
    data_sram_rdata = 32'hAAAA5555;
    #2;
    chk("flush_pre_valid", 32'(ms_to_ws_valid), 1);
    tick;
    flush = 1'b1;
    #2;
    chk("flush_pre_buf", 32'(dut.buf_valid_q), 1);
    chk("flush_to_ws_valid", 32'(ms_to_ws_valid), 0);
    chk("flush_block_valid", 32'(f_blk), 0);
    tick;
    flush = 1'b0;
    es_to_ms_valid = 1'b0;
    #2;
    chk("flush_next_valid", 32'(ms_to_ws_valid), 0);
    chk("flush_next_allowin", 32'(ms_allowin), 1);
    chk("flush_next_buf", 32'(dut.buf_valid_q), 0);
    // reset during stalled load
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b1;
    tick;
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_rdata = 32'h12121212;
    repeat (2) tick;
    reset = 1'b1;
    #2;
    chk("rst_pre_buf", 32'(dut.buf_valid_q), 1);
    tick;
    reset = 1'b0;
    #2;
    chk("rst_to_ws_valid", 32'(ms_to_ws_valid), 0);
    chk("rst_buf", 32'(dut.buf_valid_q), 0);
    chk("rst_allowin", 32'(ms_allowin), 1);
    // randomized against behavioural model
    m_valid = 1'b0;
    m_first = 1'b0;
    m_bus = '0;
    m_word = '0;
    for (int it = 0; it < 1500; it++) begin
      tick;
      es_to_ms_valid = 1'($urandom_range(0, 1));
      ws_allowin = ($urandom % 4) != 0;
      flush = ($urandom % 16) == 0;
      data_sram_rdata = $urandom;
      r_rfm = 1'($urandom_range(0, 1));
      r_ld = r_rfm ? 7'(1 << $urandom_range(0, 6)) : 7'h0;
      r_gwe = r_rfm | 1'($urandom_range(0, 1));
      r_ex = ($urandom % 8) == 0;
      es_to_ms_bus = mk_bus($urandom, 11'($urandom), 1'($urandom), r_ex, 5'($urandom), r_ld,
                            r_rfm, r_gwe, 5'($urandom), $urandom, $urandom);
      #2;
      e_allow = !m_valid || ws_allowin;
      chk("rnd_allowin", 32'(ms_allowin), 32'(e_allow));
      chk("rnd_to_ws_valid", 32'(ms_to_ws_valid), 32'(m_valid && !flush));
      chk("rnd_ms_ex", 32'(ms_ex), 32'(m_valid && m_bus[83]));
      chk("rnd_mfc0", 32'(f_mfc0), 32'(m_valid && m_bus[93]));
      chk("rnd_block", 32'(f_blk), 32'(m_valid && m_bus[69] && !flush));
      if (m_valid) begin
        word = m_first ? data_sram_rdata : m_word;
        if (m_bus[70]) ref_load(m_bus[77:71], m_bus[33:32], word, e_res, e_wen);
        else begin e_res = m_bus[63:32]; e_wen = {4{m_bus[69]}}; end
        if (m_bus[83]) e_wen = 4'h0;
        chk("rnd_result", o_res, e_res);
        chk("rnd_wen", 32'(o_wen), 32'(e_wen));
        chk("rnd_fwd_result", f_res, e_res);
        chk("rnd_fwd_wen", 32'(f_wen), 32'(e_wen));
        chk("rnd_pc", o_pc, m_bus[31:0]);
        chk("rnd_badv", o_badv, m_bus[127:96]);
        chk("rnd_misc", {7'h0, o_c0, o_bd, o_ex, o_code, o_dest}, {7'h0, m_bus[95:78], m_bus[68:64]});
      end
      if (m_valid && m_first) begin m_word = data_sram_rdata; m_first = 1'b0; end
      if (flush) m_valid = 1'b0;
      else if (e_allow) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) begin m_bus = es_to_ms_bus; m_first = 1'b1; end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
